// File: rtl/tlm_pkg.sv
// Register map, control-bit positions and handshake state encoding
// shared by the performance counter bank and its channels.
package tlm_pkg;

    localparam logic [31:0] REG_CTRL       = 32'h00;
    localparam logic [31:0] REG_STATUS     = 32'h04;
    localparam logic [31:0] REG_IRQ_EN     = 32'h08;
    localparam logic [31:0] REG_CNT_BASE   = 32'h40;
    localparam logic [31:0] REG_CNT_STRIDE = 32'h08;
    localparam logic [31:0] REG_CNT_HI_OFS = 32'h04;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_CLR  = 1;
    localparam int CTRL_SNAP = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/tlm_counter_ch.sv
// One counter channel: live count, software-visible snapshot and the
// all-ones -> zero wrap detect that feeds the sticky overflow bit.
module tlm_counter_ch #(
    parameter int CNT_W = 48
) (
    input  logic             clk,
    input  logic             rst_cpu,
    input  logic             en,
    input  logic             evt,
    input  logic             clr,
    input  logic             snap,
    input  logic             pre_lo,
    input  logic             pre_hi,
    input  logic [31:0]      pre_data,
    output logic [CNT_W-1:0] snap_val,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pre_val;
    logic [CNT_W-1:0] cnt_nxt;
    logic             inc;

    assign inc  = en && evt && !clr && !pre_lo && !pre_hi;
    assign wrap = inc && (&cnt);

    // Preload replaces one 32-bit half of the live count, truncated to CNT_W.
    if (CNT_W > 32) begin : g_wide
        always_comb begin
            pre_val = cnt;
            if (pre_lo) pre_val[31:0] = pre_data;
            if (pre_hi) pre_val[CNT_W-1:32] = pre_data[CNT_W-33:0];
        end
    end else begin : g_narrow
        always_comb begin
            pre_val = cnt;
            if (pre_lo) pre_val = pre_data[CNT_W-1:0];
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (pre_lo || pre_hi)
            cnt_nxt = pre_val;
        else if (inc)
            cnt_nxt = cnt + CNT_W'(1);
    end

    // Snapshot always sees the pre-edge count, ahead of clear/preload/increment.
    always_ff @(posedge clk or negedge rst_cpu) begin
        if (!rst_cpu) begin
            cnt      <= '0;
            snap_val <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (snap) snap_val <= cnt;
        end
    end

endmodule

// File: rtl/tlm_perf_counter_bank.sv
// Bank of NUM_CH event counters behind a single-outstanding register port:
// request accepted in IDLE, one-cycle response in RESP.
module tlm_perf_counter_bank
    import tlm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 48,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_cpu,
    input  logic [NUM_CH-1:0] event_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              ovf_irq_o
);

    state_t            state;
    logic              en_q;
    logic [NUM_CH-1:0] ovf_sticky;
    logic [NUM_CH-1:0] irq_en;

    logic              accept;
    logic              wr_acc;
    logic [31:0]       word_addr;
    logic              hit_ctrl, hit_status, hit_irq, mapped;
    logic [NUM_CH-1:0] hit_lo, hit_hi;
    logic [31:0]       rd_data;
    logic              ctrl_clr, ctrl_snap;
    logic [NUM_CH-1:0] pre_lo, pre_hi, wrap, w1c;
    logic [CNT_W-1:0]  snap_val [NUM_CH];
    logic [31:0]       lo_word  [NUM_CH];
    logic [31:0]       hi_word  [NUM_CH];

    assign accept    = req_valid_i && (state == IDLE);
    assign wr_acc    = accept && req_we_i && mapped;
    assign word_addr = 32'(req_addr_i) & ~32'h3;

    always_comb begin
        hit_ctrl   = (word_addr == REG_CTRL);
        hit_status = (word_addr == REG_STATUS);
        hit_irq    = (word_addr == REG_IRQ_EN);
        for (int i = 0; i < NUM_CH; i++) begin
            hit_lo[i] = (word_addr == REG_CNT_BASE + REG_CNT_STRIDE * 32'(i));
            hit_hi[i] = (word_addr == REG_CNT_BASE + REG_CNT_STRIDE * 32'(i) + REG_CNT_HI_OFS);
        end
        mapped = hit_ctrl || hit_status || hit_irq || (|hit_lo) || (|hit_hi);
    end

    assign ctrl_clr  = wr_acc && hit_ctrl && req_wdata_i[CTRL_CLR];
    assign ctrl_snap = wr_acc && hit_ctrl && req_wdata_i[CTRL_SNAP];
    assign pre_lo    = {NUM_CH{wr_acc}} & hit_lo;
    assign pre_hi    = {NUM_CH{wr_acc}} & hit_hi;
    assign w1c       = (wr_acc && hit_status) ? req_wdata_i[NUM_CH-1:0] : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tlm_counter_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_cpu  (rst_cpu),
            .en       (en_q),
            .evt      (event_i[i]),
            .clr      (ctrl_clr),
            .snap     (ctrl_snap),
            .pre_lo   (pre_lo[i]),
            .pre_hi   (pre_hi[i]),
            .pre_data (req_wdata_i),
            .snap_val (snap_val[i]),
            .wrap     (wrap[i])
        );

        if (CNT_W >= 32) begin : g_lo
            assign lo_word[i] = snap_val[i][31:0];
        end else begin : g_lo_ext
            assign lo_word[i] = 32'(snap_val[i]);
        end

        if (CNT_W > 32) begin : g_hi
            assign hi_word[i] = 32'(snap_val[i][CNT_W-1:32]);
        end else begin : g_hi_zero
            assign hi_word[i] = '0;
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit_ctrl)   rd_data[CTRL_EN] = en_q;
        if (hit_status) rd_data = 32'(ovf_sticky);
        if (hit_irq)    rd_data = 32'(irq_en);
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit_lo[i]) rd_data = lo_word[i];
            if (hit_hi[i]) rd_data = hi_word[i];
        end
    end

    always_ff @(posedge clk or negedge rst_cpu) begin
        if (!rst_cpu) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        state       <= RESP;
                        req_ready_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= req_we_i ? '0 : rd_data;
                        rsp_err_o   <= !mapped;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                    rsp_rdata_o <= '0;
                    rsp_err_o   <= 1'b0;
                end
            endcase
        end
    end

    // A wrap in the same edge as a W1C keeps the sticky bit set.
    always_ff @(posedge clk or negedge rst_cpu) begin
        if (!rst_cpu) begin
            en_q       <= 1'b0;
            ovf_sticky <= '0;
            irq_en     <= '0;
        end else begin
            if (wr_acc && hit_ctrl) en_q <= req_wdata_i[CTRL_EN];
            if (wr_acc && hit_irq)  irq_en <= req_wdata_i[NUM_CH-1:0];
            ovf_sticky <= (ovf_sticky & ~w1c) | wrap;
        end
    end

    assign ovf_irq_o = |(ovf_sticky & irq_en);

endmodule

// File: tb/tb_tlm_perf_counter_bank.sv
// Bench for tlm_perf_counter_bank: directed scenarios plus random traffic,
// all checked every cycle against an arithmetic model of the register map.
module tb_tlm_perf_counter_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 48;
    localparam int ADDR_W = 8;
    localparam logic [63:0] MASK = {64{1'b1}} >> (64 - CNT_W);

    logic              clk = 1'b0;
    logic              rst_cpu = 1'b1;
    logic [NUM_CH-1:0] event_i = '0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [ADDR_W-1:0] req_addr_i = '0;
    logic [31:0]       req_wdata_i = '0;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic              ovf_irq_o;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    // Model state
    logic [63:0]       m_cnt  [NUM_CH];
    logic [63:0]       m_snap [NUM_CH];
    logic [NUM_CH-1:0] m_sticky, m_irq;
    bit                m_en, m_ready, m_rv, m_err;
    logic [31:0]       m_rdata;

    tlm_perf_counter_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_cpu     (rst_cpu),
        .event_i     (event_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .ovf_irq_o   (ovf_irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i]  = '0;
            m_snap[i] = '0;
        end
        m_sticky = '0;
        m_irq    = '0;
        m_en     = 0;
        m_ready  = 1;
        m_rv     = 0;
        m_err    = 0;
        m_rdata  = '0;
    endtask

    task automatic m_read(input logic [7:0] a8, output logic [31:0] d, output logic e);
        int a, ch;
        a = int'(a8) & ~3;
        d = '0;
        e = 0;
        if (a == 0) d = {31'b0, m_en};
        else if (a == 4) d = 32'(m_sticky);
        else if (a == 8) d = 32'(m_irq);
        else if (a >= 64 && a < 64 + 8 * NUM_CH) begin
            ch = (a - 64) / 8;
            d = ((a - 64) % 8 == 0) ? m_snap[ch][31:0] : m_snap[ch][63:32];
        end else e = 1;
    endtask

    // Advance the model by one clock edge using the inputs presented before it.
    task automatic model_step();
        logic [31:0] d;
        logic e;
        int a, ch;
        bit acc, clr, snp, new_en;
        logic [NUM_CH-1:0] w1c, plo, phi, wraps;
        if (!rst_cpu) return;
        acc = req_valid_i && m_ready;
        clr = 0; snp = 0; new_en = m_en;
        w1c = '0; plo = '0; phi = '0; wraps = '0;
        if (acc) begin
            m_read(req_addr_i, d, e);
            m_rv    = 1;
            m_err   = e;
            m_rdata = req_we_i ? 32'h0 : d;
            if (req_we_i && !e) begin
                a = int'(req_addr_i) & ~3;
                if (a == 0) begin
                    new_en = req_wdata_i[0];
                    clr    = req_wdata_i[1];
                    snp    = req_wdata_i[2];
                end else if (a == 4) w1c = req_wdata_i[NUM_CH-1:0];
                else if (a == 8) m_irq = req_wdata_i[NUM_CH-1:0];
                else begin
                    ch = (a - 64) / 8;
                    if ((a - 64) % 8 == 4) phi[ch] = 1'b1;
                    else plo[ch] = 1'b1;
                end
            end
        end else m_rv = 0;
        m_ready = !acc;
        for (int i = 0; i < NUM_CH; i++) begin
            if (snp) m_snap[i] = m_cnt[i];
            if (clr) m_cnt[i] = '0;
            else if (plo[i]) m_cnt[i] = ((m_cnt[i] & 64'hFFFF_FFFF_0000_0000) | 64'(req_wdata_i)) & MASK;
            else if (phi[i]) m_cnt[i] = ((m_cnt[i] & 64'h0000_0000_FFFF_FFFF) | (64'(req_wdata_i) << 32)) & MASK;
            else if (m_en && event_i[i]) begin
                if (m_cnt[i] == MASK) begin
                    m_cnt[i] = '0;
                    wraps[i] = 1'b1;
                end else m_cnt[i] = m_cnt[i] + 64'd1;
            end
        end
        m_sticky = (m_sticky & ~w1c) | wraps;
        m_en = new_en;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input logic exp_err, input string nm);
        req_valid_i = 1; req_we_i = 0; req_addr_i = a; req_wdata_i = $urandom;
        step();
        req_valid_i = 0;
        chk({nm, "_vld"}, 32'(rsp_valid_o), 32'd1);
        chk({nm, "_rdy"}, 32'(req_ready_o), 32'd0);
        chk({nm, "_data"}, rsp_rdata_o, exp);
        chk({nm, "_err"}, 32'(rsp_err_o), 32'(exp_err));
        step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] data, input logic exp_err, input string nm);
        req_valid_i = 1; req_we_i = 1; req_addr_i = a; req_wdata_i = data;
        step();
        req_valid_i = 0; req_we_i = 0;
        chk({nm, "_vld"}, 32'(rsp_valid_o), 32'd1);
        chk({nm, "_data"}, rsp_rdata_o, 32'h0);
        chk({nm, "_err"}, 32'(rsp_err_o), 32'(exp_err));
        step();
    endtask

    // Continuous comparison against the model, half a cycle after each edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("cyc_ready", 32'(req_ready_o), 32'(m_ready));
                chk("cyc_rsp_valid", 32'(rsp_valid_o), 32'(m_rv));
                chk("cyc_irq", 32'(ovf_irq_o), 32'(|(m_sticky & m_irq)));
                if (m_rv) begin
                    chk("cyc_rdata", rsp_rdata_o, m_rdata);
                    chk("cyc_err", 32'(rsp_err_o), 32'(m_err));
                end
            end
        end
    end

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        model_reset();
        #1 rst_cpu = 0;
        #2;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_err", 32'(rsp_err_o), 32'd0);
        chk("rst_irq", 32'(ovf_irq_o), 32'd0);
        chk_on = 1;
        step();
        step();
        rst_cpu = 1;
        step();

        rd(8'h40, 32'h0, 0, "idle_rd");

        // 1000 events on channel 0
        wr(8'h00, 32'h1, 0, "en_on");
        event_i = 4'b0001;
        repeat (1000) step();
        event_i = '0;
        wr(8'h00, 32'h0, 0, "en_off");
        wr(8'h00, 32'h4, 0, "snap1");
        rd(8'h40, 32'h0000_03E8, 0, "ch0_lo");
        rd(8'h44, 32'h0, 0, "ch0_hi");
        rd(8'h48, 32'h0, 0, "ch1_lo0");
        rd(8'h50, 32'h0, 0, "ch2_lo0");
        rd(8'h5C, 32'h0, 0, "ch3_hi0");

        // Wrap on channel 1 with overflow interrupt
        wr(8'h48, 32'hFFFF_FFFF, 0, "pre_lo");
        wr(8'h4C, 32'h0000_FFFF, 0, "pre_hi");
        wr(8'h08, 32'h2, 0, "irq_en");
        wr(8'h00, 32'h1, 0, "en_on2");
        event_i = 4'b0010;
        step();
        step();
        event_i = '0;
        wr(8'h00, 32'h4, 0, "snap2");
        rd(8'h48, 32'h1, 0, "wrap_lo");
        rd(8'h4C, 32'h0, 0, "wrap_hi");
        rd(8'h04, 32'h2, 0, "status");
        chk("irq_set", 32'(ovf_irq_o), 32'd1);
        wr(8'h04, 32'h2, 0, "w1c");
        chk("irq_clr", 32'(ovf_irq_o), 32'd0);

        // EN|CLR|SNAP with counter at 5 and events continuing
        wr(8'h00, 32'h3, 0, "clr_en");
        event_i = 4'b0001;
        repeat (5) step();
        wr(8'h00, 32'h7, 0, "clr_snap");
        rd(8'h40, 32'h5, 0, "snap_old");
        wr(8'h00, 32'h5, 0, "snap3");
        event_i = '0;
        rd(8'h40, 32'h3, 0, "since_clr");
        wr(8'h00, 32'h0, 0, "en_off3");

        // Unmapped accesses leave state alone
        rd(8'h0C, 32'h0, 1, "unm_rd");
        wr(8'h3C, 32'hFFFF_FFFF, 1, "unm_wr");
        rd(8'h60, 32'h0, 1, "unm_hi");
        rd(8'h00, 32'h0, 0, "ctrl_keep");
        rd(8'h08, 32'h2, 0, "irq_keep");
        rd(8'h04, 32'h0, 0, "stat_keep");
        rd(8'h40, 32'h3, 0, "snap_keep");

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            event_i     = NUM_CH'($urandom);
            req_valid_i = ($urandom_range(0, 2) == 0);
            req_we_i    = $urandom_range(0, 1);
            d           = $urandom;
            case ($urandom_range(0, 7))
                0: begin
                    a = 8'h00;
                    d = {d[31:3], ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
                         ($urandom_range(0, 7) != 0)};
                end
                1: a = 8'h04;
                2: a = 8'h08;
                3, 4: begin
                    a = 8'(64 + 8 * $urandom_range(0, NUM_CH - 1));
                    d = 32'hFFFF_FFC0 | (d & 32'h3F);
                end
                5: begin
                    a = 8'(68 + 8 * $urandom_range(0, NUM_CH - 1));
                    if ($urandom_range(0, 1) == 0) d = 32'h0000_FFFF;
                end
                6: a = 8'($urandom_range(0, 255));
                default: a = ($urandom_range(0, 1) == 0) ? 8'h0C : 8'h60;
            endcase
            req_addr_i  = a;
            req_wdata_i = d;
            step();
        end
        req_valid_i = 0;
        event_i     = '0;
        step();
        step();

        // Asynchronous reset during a response
        wr(8'h00, 32'h3, 0, "pre_rst_clr");
        wr(8'h40, 32'h123, 0, "pre_rst_ld");
        wr(8'h00, 32'h4, 0, "pre_rst_snap");
        rd(8'h40, 32'h123, 0, "pre_rst_rd");
        req_valid_i = 1; req_we_i = 0; req_addr_i = 8'h40;
        step();
        req_valid_i = 0;
        chk("inflight_vld", 32'(rsp_valid_o), 32'd1);
        rst_cpu = 0;
        model_reset();
        #1;
        chk("arst_valid", 32'(rsp_valid_o), 32'd0);
        chk("arst_ready", 32'(req_ready_o), 32'd1);
        step();
        step();
        rst_cpu = 1;
        step();
        for (int i = 0; i < 2 * NUM_CH; i++) begin
            rd(8'(64 + 4 * i), 32'h0, 0, "post_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlm_perf_counter_bank.md
Name: tlm_perf_counter_bank

Overview:
- Parametrised telemetry block: NUM_CH independent event counters of CNT_W bits each.
- Counters are exposed through a memory-mapped register port attached to the core's MMIO decode.
- Successor to the fixed mcycle/minstret/stall triple; adds global enable, clear, coherent snapshot, preload, sticky overflow and a maskable overflow interrupt.
- Software reads snapshots and stores them to TCM for post-run inspection.

Parameters:
NUM_CH, 4, number of counter channels (1..16)
CNT_W, 48, counter width in bits (1..64)
ADDR_W, 8, register-port byte-address width (must cover 0x40+8*NUM_CH)

Ports:
clk  input  1  clock
rst_cpu  input  1  reset; asynchronous, active-low
event_i  input  NUM_CH  per-channel increment strobe, one count per cycle when high
req_valid_i  input  1  register request valid
req_ready_o  output  1  register port can accept a request
req_we_i  input  1  1=write, 0=read
req_addr_i  input  ADDR_W  byte address; bits [1:0] ignored
req_wdata_i  input  32  write data
rsp_valid_o  output  1  response strobe, one cycle
rsp_rdata_o  output  32  read data (0 for writes)
rsp_err_o  output  1  unmapped address, qualified by rsp_valid_o
ovf_irq_o  output  1  level interrupt = |(ovf_sticky & irq_en)

Behaviour:
- Reset values: all counters, snapshots, ovf_sticky, irq_en and CTRL.EN are 0. State is IDLE.
- Reset output values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, ovf_irq_o=0.
- Register map (offsets):
  - 0x00 CTRL: bit0 EN (R/W); bit1 CLR (write-1 pulse, reads 0); bit2 SNAP (write-1 pulse, reads 0).
  - 0x04 STATUS: ovf_sticky[NUM_CH-1:0], W1C.
  - 0x08 IRQ_EN[NUM_CH-1:0], R/W.
  - 0x40+8*i CNT_LO(i); 0x44+8*i CNT_HI(i).
  - Anything else is unmapped.
- Handshake FSM, two states:
  - IDLE: req_ready_o=1. On req_valid_i go to RESP, registering the decode and, for writes, applying the write at that clock edge.
  - RESP: rsp_valid_o=1 for exactly one cycle, req_ready_o=0, then return to IDLE.
  - Latency is 1 cycle; maximum throughput is one request per 2 cycles. There is no response backpressure.
- Reads of CNT_LO/HI return the snapshot register, never the live counter.
  - LO = snap[31:0].
  - HI = snap[CNT_W-1:32], zero-extended. HI reads 0 when CNT_W<=32.
- Writes to CNT_LO/HI preload the live counter bits (truncated to CNT_W) and leave the snapshot unchanged.
- Counting: when EN=1 and event_i[i]=1, cnt[i] increments by 1 per cycle, modulo 2^CNT_W.
  - On all-ones -> 0 wrap, ovf_sticky[i] is set in the same edge.
- Priority per channel in one cycle: CLR > preload write > increment.
- SNAP captures the live values before any same-cycle CLR, preload or increment.
- A CTRL write with both CLR=1 and SNAP=1 captures the old values, then zeroes the counters.
- CLR does not clear ovf_sticky. A STATUS W1C colliding with a same-cycle wrap leaves the bit set (set wins).
- EN written 0 freezes counting from the next edge; EN written 1 counts events from the next cycle.
- Unmapped read or write: rsp_rdata_o=0, rsp_err_o=1, no state change.
- Reset asserted mid-transaction: asynchronous return to reset values; an in-flight response is dropped.
- ovf_irq_o is a combinational AND-OR of registered state; no glitch from event_i.

Decomposition:
- Shared package tlm_pkg holds:
  - register offsets: CTRL=0x00, STATUS=0x04, IRQ_EN=0x08, CNT_BASE=0x40, CNT_STRIDE=8;
  - CTRL bit indices: EN=0, CLR=1, SNAP=2;
  - FSM state enum {IDLE, RESP}.
- One sub-module, tlm_counter_ch, is instantiated NUM_CH times.
  - It holds one live counter, its snapshot and the wrap detect.
  - Inputs: en, evt, clr, snap, preload strobes/data. Outputs: snapshot, wrap pulse.
- The top level holds the FSM, address decode, STATUS/IRQ_EN and read mux.

Test Plan:
- Reset then idle read of 0x40 -> rsp_valid_o exactly 1 cycle after accept, rdata=0x0, err=0; req_ready_o low during that response cycle.
- EN=1, event_i[0] high for 1000 cycles, EN=0, SNAP, read 0x40/0x44 -> 0x000003E8 / 0x00000000; other channels read 0.
- CNT_W=48: preload ch1 LO=0xFFFFFFFF, HI=0xFFFF, EN=1, IRQ_EN=0x2, 2 events, SNAP -> LO=0x1, HI=0x0, STATUS=0x2, ovf_irq_o=1; W1C 0x2 to STATUS -> ovf_irq_o=0.
- Counter at 5 with events continuing, write CTRL=0x7 (EN|CLR|SNAP) -> snapshot reads 5; live counter 0 at the next edge; a later SNAP shows counts since the clear.
- Read 0x0C and write 0x3C -> rsp_err_o=1, rdata=0, all registers unchanged.
- rst_cpu asserted while in RESP with counters at 0x123 -> immediately rsp_valid_o=0, req_ready_o=1, and after release all snapshot reads return 0.
